// File: rtl/mips16e_reg_file.sv
// mips16e_reg_file
//
// Register file for a MIPS16e-style core: eleven word_size-bit entries
// (0-7 general purpose, 8 = T, 9 = SP, 10 = RA) with one write port and
// two independent registered read ports. Addresses 11-15 have no storage.
// Reads of those addresses return zero, writes to them are dropped, and
// either kind of access raises a registered addr_err flag for one cycle.
//
// Ports:
//   clk      - rising-edge clock for all state
//   rst      - synchronous active-high reset (clears entries, SP loads SP_RESET)
//   we       - write enable
//   waddr    - write address (4 bits)
//   wdata    - write data
//   re_a     - read enable, port A (rdata_a holds its value when low)
//   raddr_a  - read address, port A
//   rdata_a  - registered read data, port A
//   re_b     - read enable, port B
//   raddr_b  - read address, port B
//   rdata_b  - registered read data, port B
//   addr_err - registered flag: the previous cycle touched an unmapped address

module mips16e_reg_file #(
    parameter int                   word_size = 16,
    parameter logic [word_size-1:0] SP_RESET  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [3:0]           waddr,
    input  logic [word_size-1:0] wdata,
    input  logic                 re_a,
    input  logic [3:0]           raddr_a,
    output logic [word_size-1:0] rdata_a,
    input  logic                 re_b,
    input  logic [3:0]           raddr_b,
    output logic [word_size-1:0] rdata_b,
    output logic                 addr_err
);

    localparam int         num_entries = 11;
    localparam logic [3:0] last_addr   = 4'd10;
    localparam int         sp_index    = 9;

    logic [word_size-1:0] regs [0:num_entries-1];

    logic                 write_hit;
    logic [word_size-1:0] read_a_val;
    logic [word_size-1:0] read_b_val;
    logic                 err_next;

    function automatic logic is_mapped(input logic [3:0] addr);
        return addr <= last_addr;
    endfunction

    // A write only reaches storage when it targets a mapped entry.
    assign write_hit = we && is_mapped(waddr);

    // Read data selection. A read of the entry being written this same cycle
    // forwards wdata so the port never returns a stale value; unmapped
    // addresses read as zero.
    always_comb begin
        read_a_val = '0;
        read_b_val = '0;
        if (is_mapped(raddr_a)) begin
            if (write_hit && (waddr == raddr_a)) begin
                read_a_val = wdata;
            end else begin
                read_a_val = regs[raddr_a];
            end
        end
        if (is_mapped(raddr_b)) begin
            if (write_hit && (waddr == raddr_b)) begin
                read_b_val = wdata;
            end else begin
                read_b_val = regs[raddr_b];
            end
        end
    end

    // Any enabled access to an unmapped address flags an error next cycle.
    assign err_next = (we   && !is_mapped(waddr))   ||
                      (re_a && !is_mapped(raddr_a)) ||
                      (re_b && !is_mapped(raddr_b));

    // Storage. Reset wins over a coincident write, so that write is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < num_entries; i++) begin
                regs[i] <= (i == sp_index) ? SP_RESET : '0;
            end
        end else if (write_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Output registers; a disabled port keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            addr_err <= 1'b0;
        end else begin
            if (re_a) begin
                rdata_a <= read_a_val;
            end
            if (re_b) begin
                rdata_b <= read_b_val;
            end
            addr_err <= err_next;
        end
    end

endmodule

// File: doc/mips16e_reg_file.md
MIPS16E_REG_FILE -- requirements
Module: mips16e_reg_file

Interface
REQ-001 The block SHALL have parameter word_size, default 16, the width of every data port and storage entry.
REQ-002 The block SHALL have parameter SP_RESET, default 16'h0000, the reset value of entry 9 (SP).
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port we, input, 1: write enable.
REQ-006 Port waddr, input, 4: write address.
REQ-007 Port wdata, input, word_size: write data.
REQ-008 Port re_a, input, 1: read enable, port A.
REQ-009 Port raddr_a, input, 4: read address, port A.
REQ-010 Port rdata_a, output, word_size: registered read data, port A.
REQ-011 Port re_b, input, 1: read enable, port B.
REQ-012 Port raddr_b, input, 4: read address, port B.
REQ-013 Port rdata_b, output, word_size: registered read data, port B.
REQ-014 Port addr_err, output, 1: registered flag for an access to an unmapped address.

Function
REQ-015 Storage SHALL be 11 entries of word_size bits: 0-7 GPRs, 8 T, 9 SP, 10 RA.
REQ-016 Addresses 11-15 SHALL be unmapped and have no storage.
REQ-017 When we=1 and waddr<=10, entry waddr SHALL take wdata at the rising edge.
REQ-018 When we=1 and waddr>=11, storage SHALL not change.
REQ-019 When re_a=1, rdata_a SHALL update at the next edge (1-cycle latency).
REQ-020 When re_a=0, rdata_a SHALL hold its previous value.
REQ-021 Port B SHALL behave identically to port A, using re_b, raddr_b and rdata_b.
REQ-022 A read of an unmapped address SHALL return 0.
REQ-023 Write-through bypass: when re_x=1, we=1 and raddr_x==waddr<=10 in the same cycle, rdata_x SHALL take wdata, not the old entry value.
REQ-024 Both ports MAY read the same address in the same cycle; both SHALL return identical data.
REQ-025 addr_err SHALL be set at the next edge when any of these holds, and cleared otherwise:
- (we=1 and waddr>=11)
- (re_a=1 and raddr_a>=11)
- (re_b=1 and raddr_b>=11)
REQ-026 The block SHALL contain no combinational path from any input to rdata_a, rdata_b or addr_err.

Reset
REQ-027 When rst=1 at a rising edge, all entries SHALL clear to 0, except SP, which SHALL load SP_RESET.
REQ-028 When rst=1 at a rising edge, rdata_a=0, rdata_b=0 and addr_err=0.
REQ-029 rst SHALL take priority over we, re_a and re_b in the same cycle; a write presented during reset SHALL be lost.
REQ-030 The first write after reset deasserts SHALL be accepted in the first cycle with rst=0.

Verification
REQ-031 Reset with SP_RESET=16'hFFF0, then read addr 9 on A and addr 3 on B -> next cycle rdata_a=16'hFFF0, rdata_b=0, addr_err=0.
REQ-032 Write 16'h1234 to addr 5; next cycle read addr 5 on A -> rdata_a=16'h1234 one cycle after the read request.
REQ-033 Same cycle: we=1, waddr=10, wdata=16'hBEEF, re_a=1, raddr_a=10; RA previously 16'h0001 -> next cycle rdata_a=16'hBEEF.
REQ-034 Write 16'h5555 to addr 12, then read addr 12 on B:
- after the write: addr_err=1 and all 11 entries unchanged;
- after the read: rdata_b=0 and addr_err=1;
- a following idle cycle: addr_err=0.
REQ-035 Hold re_a=0 for 3 cycles while entry raddr_a is rewritten -> rdata_a unchanged throughout.
REQ-036 Assert rst in the same cycle as a write of 16'hAAAA to addr 2, then read addr 2 -> rdata_a=0.
